// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product datapath: bfloat16 lane geometry and
// the vector loader state encoding.
package dotprod_pkg;

  localparam int BF16_W = 16;
  localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

  // Lane i of a flat [0:N*16-1] vector starts at bit i*16 and spans 16 bits.
  function automatic int lane_base(input int lane);
    return lane * BF16_W;
  endfunction

endpackage

// File: rtl/dotprod_vec_loader.sv
// Packs one bfloat16 pair per accepted beat into horz/vert; the vector is presented one edge after
// its last accept when the output stage is free, and in_ready drops while a completed vector waits.
module dotprod_vec_loader
  import dotprod_pkg::*;
#(
  parameter int VEC_LENGTH = 10,
  parameter int BIT_LENGTH = VEC_LENGTH * 16,
  parameter int CNT_W      = $clog2(VEC_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:15]           in_a,
  input  logic [0:15]           in_b,
  input  logic                  in_last,
  output logic [0:BIT_LENGTH-1] horz,
  output logic [0:BIT_LENGTH-1] vert,
  output logic [CNT_W-1:0]      vec_lanes,
  output logic                  vec_valid,
  input  logic                  vec_ready
);

  loader_state_e         state;
  logic [0:BIT_LENGTH-1] fill_a;
  logic [0:BIT_LENGTH-1] fill_b;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      lanes_lat;
  logic                  final_lane;

  assign in_ready   = (state == FILL);
  assign final_lane = (count == CNT_W'(VEC_LENGTH - 1)) || in_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_a    <= {VEC_LENGTH{BF16_ZERO}};
      fill_b    <= {VEC_LENGTH{BF16_ZERO}};
      count     <= '0;
      lanes_lat <= '0;
      horz      <= '0;
      vert      <= '0;
      vec_lanes <= '0;
      vec_valid <= 1'b0;
    end else begin
      // Consumption clears valid; a same-edge transfer below overrides it.
      if (vec_valid && vec_ready)
        vec_valid <= 1'b0;

      case (state)
        FILL: begin
          if (in_valid) begin
            fill_a[lane_base(int'(count)) +: BF16_W] <= in_a;
            fill_b[lane_base(int'(count)) +: BF16_W] <= in_b;
            count <= count + CNT_W'(1);
            if (final_lane) begin
              lanes_lat <= count + CNT_W'(1);
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!vec_valid || vec_ready) begin
            horz      <= fill_a;
            vert      <= fill_b;
            vec_lanes <= lanes_lat;
            vec_valid <= 1'b1;
            // Clearing here is what zero-pads lanes skipped by an early in_last.
            fill_a    <= {VEC_LENGTH{BF16_ZERO}};
            fill_b    <= {VEC_LENGTH{BF16_ZERO}};
            count     <= '0;
            state     <= FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dotprod_vec_loader.md
Name: dotprod_vec_loader

Overview:
Producer end of the dot-product vector interface. It accepts one bfloat16 operand pair per cycle over a valid/ready stream and packs the pairs lane by lane into two flat vectors. It presents the packed horz/vert vectors, held stable, to the dotprod unit with a valid/ready handshake. Short vectors, terminated early with in_last, are zero-padded so unused multiplier lanes produce +0.

Parameters:
VEC_LENGTH, 10, number of bfloat16 lanes per vector.
BIT_LENGTH, VEC_LENGTH*16, width of each flat vector bus.
CNT_W, $clog2(VEC_LENGTH+1), width of the lane counter and of vec_lanes.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  loader can accept a pair this cycle.
in_a  input  [0:15]  bfloat16 element for horz.
in_b  input  [0:15]  bfloat16 element for vert.
in_last  input  1  marks the final pair of the current vector; qualified by in_valid.
horz  output  [0:BIT_LENGTH-1]  packed vector A; lane i occupies bits [i*16 : i*16+15].
vert  output  [0:BIT_LENGTH-1]  packed vector B; same lane layout as horz.
vec_lanes  output  [CNT_W-1:0]  number of valid lanes in the presented vector, 1..VEC_LENGTH.
vec_valid  output  1  horz/vert/vec_lanes hold a complete vector.
vec_ready  input  1  downstream consumes the vector this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): horz=0, vert=0, vec_lanes=0, vec_valid=0, fill buffer cleared to 16'h0000 in every lane, lane count=0, state=FILL. in_ready reads 1 once state is FILL. Reset mid-vector discards the partial vector and any presented vector.
- Accept = in_valid && in_ready at a rising edge. On accept, in_a and in_b are written into lane `count` of the fill buffer, and count increments.
- in_ready = (state==FILL). It is decoded from state only, with no combinational path from in_valid or vec_ready.
- FSM states:
  - FILL: accepting pairs. An accept with count==VEC_LENGTH-1 or with in_last=1 moves the FSM to HOLD; the final lane count is latched.
  - HOLD: in_ready=0. The transfer condition is (!vec_valid || vec_ready) at an edge.
  - On transfer: the fill buffer is copied into horz/vert, vec_lanes is set to the latched count, vec_valid=1, the fill buffer is cleared to zero, count=0, and the FSM returns to FILL.
  - A HOLD vector therefore reaches the output one edge after the completing accept, provided the output stage is free.
- Output handshake: while vec_valid=1 and vec_ready=0, horz/vert/vec_lanes hold stable.
- Output handshake: vec_valid=1 with vec_ready=1 and no transfer in the same edge drives vec_valid to 0. Output data is not cleared.
- Simultaneous events: if vec_ready=1 consumes the current vector at the same edge that a HOLD transfer occurs, the new vector replaces it and vec_valid stays 1, giving zero bubble on the output.
- Throughput: at most one vector every VEC_LENGTH+1 cycles, because HOLD costs one cycle.
- Padding: lanes not written before in_last are 16'h0000 (bfloat16 +0) in the presented vector.
- in_last on the first pair gives vec_lanes=1. in_last on lane VEC_LENGTH-1 is equivalent to natural completion.
- in_last is ignored when in_valid=0. in_a, in_b and in_last are don't-care when not accepted.
- No arithmetic is performed; element bits pass through unmodified, including NaN and denormal patterns.

Decomposition:
- Shared package dotprod_pkg holds:
  - BF16_W=16.
  - BF16_ZERO=16'h0000.
  - Lane-slice helper (lane i -> bits [i*16 : i*16+15]), shared with dotprod and future adder-tree blocks.
  - Loader FSM state encoding: FILL=1'b0, HOLD=1'b1.
- No sub-module is natural: the fill buffer, lane counter and output register are written inline in this module.

Test Plan:
- VEC_LENGTH=4. Stream the pairs (16'h3F80,16'h4000), (16'h4040,16'h4080), (16'h40A0,16'h40C0), (16'h40E0,16'h4100) with vec_ready=1. Required response: one edge after the 4th accept, vec_valid=1, horz=64'h3F80_4040_40A0_40E0, vert=64'h4000_4080_40C0_4100, vec_lanes=4; in_ready is 0 for exactly one cycle.
- VEC_LENGTH=4. Send 2 pairs with in_last on the 2nd, then a full vector. Required response for the first vector: horz=64'hAAAA_BBBB_0000_0000 with vec_lanes=2. Required response for the next full vector: no stale lanes remain.
- Backpressure: hold vec_ready=0 while streaming 2 full vectors. Required response: the first vector holds stable; the second vector stalls in HOLD with in_ready=0. Raising vec_ready for one cycle makes the second vector appear on the next edge with vec_valid staying 1.
- Assert rst_n=0 asynchronously, between clock edges, after 2 accepts. Required response: outputs read 0 immediately; after release, a full vector shows no residue of the pre-reset lanes.
- Default VEC_LENGTH=10 with random in_valid gaps and random vec_ready. Required response: a scoreboard matches every output vector and its lane count, and the stability checker passes whenever vec_valid=1 and vec_ready=0.
